// File: rtl/sha256_pkg.sv
// Types shared by the packet-ID issuer, the ID buffer and the
// downstream hash-engine consumers.
package sha256_pkg;

    localparam int ID_W = 6;

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic last;
        id_t  id;
    } id_entry_t;

endpackage

// File: rtl/sha256_id_buf_if.sv
// Valid/ready ID stream into and out of the ID buffer,
// plus the debug occupancy count.
interface sha256_id_buf_if
    import sha256_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    id_t           id_in;
    logic          id_in_last;
    logic          id_in_valid;
    logic          id_in_ready;
    id_t           id_out;
    logic          id_out_last;
    logic          id_out_valid;
    logic          id_out_ready;
    logic [CW-1:0] count;

    modport slave (
        input  id_in, id_in_last, id_in_valid, id_out_ready,
        output id_in_ready, id_out, id_out_last, id_out_valid, count
    );

    modport master (
        output id_in, id_in_last, id_in_valid, id_out_ready,
        input  id_in_ready, id_out, id_out_last, id_out_valid, count
    );

endinterface

// File: rtl/sha256_fifo.sv
// Generic storage and wrap-bit pointer logic with a registered head;
// exports next-cycle full/empty so callers can register their flags.
module sha256_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full_nxt,
    output logic          empty_nxt,
    output logic [PW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [W-1:0]  head_q, head_d;

    always_comb begin
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);
        // An entry written this cycle may already be the next head.
        if (push && (wr_q[AW-1:0] == rd_d[AW-1:0]))
            head_d = wdata;
        else
            head_d = mem_q[rd_d[AW-1:0]];
    end

    assign empty_nxt = (wr_d == rd_d);
    assign full_nxt  = (wr_d[AW-1:0] == rd_d[AW-1:0]) &&
                       (wr_d[AW] != rd_d[AW]);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (!empty_nxt)
                head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= wdata;
    end

    assign rdata = head_q;
    assign count = wr_q - rd_q;

endmodule

// File: rtl/sha256_id_buf.sv
// FWFT buffer between the packet-ID issuer and the hash engine;
// registered ready/valid with enable gating.
module sha256_id_buf
    import sha256_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  nrst,
    input  logic  en,
    input  logic  sync_rst,
    sha256_id_buf_if.slave b
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(id_entry_t);

    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          push, pop;
    logic          full_nxt, empty_nxt;
    logic [EW-1:0] rd_raw;
    logic [CW-1:0] cnt;
    id_entry_t     wr_e, rd_e;

    assign push = b.id_in_valid && ready_q;
    assign pop  = valid_q && b.id_out_ready;

    assign wr_e.last = b.id_in_last;
    assign wr_e.id   = b.id_in;

    sha256_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (nrst),
        .clr       (sync_rst),
        .push      (push),
        .pop       (pop),
        .wdata     (wr_e),
        .rdata     (rd_raw),
        .full_nxt  (full_nxt),
        .empty_nxt (empty_nxt),
        .count     (cnt)
    );

    always_comb begin
        ready_d = en && !full_nxt;
        valid_d = en && !empty_nxt;
    end

    always_ff @(posedge clk) begin
        if (!nrst || sync_rst) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign rd_e           = id_entry_t'(rd_raw);
    assign b.id_in_ready  = ready_q;
    assign b.id_out_valid = valid_q;
    assign b.id_out       = rd_e.id;
    assign b.id_out_last  = rd_e.last;
    assign b.count        = cnt;

endmodule

// File: tb/tb_sha256_id_buf.sv
// Directed self-checking bench for sha256_id_buf (DEPTH=4, ID_W=6).
module tb_sha256_id_buf;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    logic en;
    logic sync_rst;
    int   checks = 0;
    int   fails  = 0;

    sha256_id_buf_if #(.DEPTH(4)) bus ();

    sha256_id_buf #(.DEPTH(4)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .sync_rst (sync_rst),
        .b        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [5:0] id;
        logic       last;
        logic       ordy;
        logic       e_rdy;
        logic       e_vld;
        logic [5:0] e_id;
        logic       e_last;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tab[11];
    int   q_id[$];
    int   q_last[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, int id, logic l, logic ordy);
        bus.id_in_valid  = v;
        bus.id_in        = id_t'(id);
        bus.id_in_last   = l;
        bus.id_out_ready = ordy;
    endtask

    // Pop everything left in q_id/q_last, checking order and flags.
    task automatic drain(string nm);
        drive(1'b0, 0, 1'b0, 1'b1);
        while (q_id.size() > 0) begin
            chk({nm, "_vld"}, 32'(bus.id_out_valid), 32'd1);
            chk({nm, "_id"}, 32'(bus.id_out), 32'(q_id.pop_front()));
            chk({nm, "_last"}, 32'(bus.id_out_last),
                32'(q_last.pop_front()));
            step();
        end
        chk({nm, "_empty"}, 32'(bus.id_out_valid), 32'd0);
        chk({nm, "_cnt0"}, 32'(bus.count), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic fill(int base, int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + i, 1'(i == n - 1), 1'b0);
            q_id.push_back(base + i);
            q_last.push_back(int'(i == n - 1));
            step();
        end
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        tab[0]  = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 3'd0};
        tab[1]  = '{1'b1, 6'd5, 1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 3'd1};
        tab[2]  = '{1'b1, 6'd6, 1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 3'd2};
        tab[3]  = '{1'b1, 6'd7, 1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 3'd3};
        tab[4]  = '{1'b1, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 3'd4};
        tab[5]  = '{1'b1, 6'd9, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 3'd4};
        tab[6]  = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd6, 1'b0, 3'd3};
        tab[7]  = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd7, 1'b0, 3'd2};
        tab[8]  = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd8, 1'b1, 3'd1};
        tab[9]  = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 3'd0};
        tab[10] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 3'd0};

        nrst     = 1'b0;
        en       = 1'b1;
        sync_rst = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_rdy", 32'(bus.id_in_ready), 32'd0);
        chk("rst_vld", 32'(bus.id_out_valid), 32'd0);
        chk("rst_cnt", 32'(bus.count), 32'd0);
        chk("rst_id", 32'(bus.id_out), 32'd0);
        chk("rst_last", 32'(bus.id_out_last), 32'd0);
        nrst = 1'b1;

        // Reset/idle, fill to full, refused fifth ID, in-order drain.
        for (int i = 0; i < 11; i++) begin
            drive(tab[i].vld, int'(tab[i].id), tab[i].last, tab[i].ordy);
            step();
            chk($sformatf("tab%0d_rdy", i), 32'(bus.id_in_ready),
                32'(tab[i].e_rdy));
            chk($sformatf("tab%0d_vld", i), 32'(bus.id_out_valid),
                32'(tab[i].e_vld));
            chk($sformatf("tab%0d_cnt", i), 32'(bus.count),
                32'(tab[i].e_cnt));
            if (tab[i].e_vld) begin
                chk($sformatf("tab%0d_id", i), 32'(bus.id_out),
                    32'(tab[i].e_id));
                chk($sformatf("tab%0d_last", i), 32'(bus.id_out_last),
                    32'(tab[i].e_last));
            end
        end

        // Streaming: one ID per cycle, occupancy held at 1, pointer wrap.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i, 1'(i == 19), 1'b1);
            chk($sformatf("t3_rdy%0d", i), 32'(bus.id_in_ready), 32'd1);
            if (i > 0) begin
                chk($sformatf("t3_vld%0d", i), 32'(bus.id_out_valid), 32'd1);
                chk($sformatf("t3_id%0d", i), 32'(bus.id_out), 32'(i - 1));
                chk($sformatf("t3_last%0d", i), 32'(bus.id_out_last), 32'd0);
            end
            step();
            chk($sformatf("t3_cnt%0d", i), 32'(bus.count), 32'd1);
        end
        q_id.push_back(19);
        q_last.push_back(1);
        drain("t3_tail");

        // Full FIFO: push refused while the pop goes, accepted next cycle.
        fill(10, 4);
        chk("t4_full_cnt", 32'(bus.count), 32'd4);
        chk("t4_full_rdy", 32'(bus.id_in_ready), 32'd0);
        drive(1'b1, 14, 1'b0, 1'b1);
        step();
        void'(q_id.pop_front());
        void'(q_last.pop_front());
        chk("t4_cnt3", 32'(bus.count), 32'd3);
        chk("t4_rdy1", 32'(bus.id_in_ready), 32'd1);
        chk("t4_head", 32'(bus.id_out), 32'd11);
        drive(1'b1, 14, 1'b0, 1'b0);
        step();
        q_id.push_back(14);
        q_last.push_back(0);
        chk("t4_cnt4", 32'(bus.count), 32'd4);
        chk("t4_rdy0", 32'(bus.id_in_ready), 32'd0);
        drain("t4");

        // Enable low freezes two entries; they resume intact.
        drive(1'b1, 20, 1'b1, 1'b0);
        q_id.push_back(20);
        q_last.push_back(1);
        step();
        drive(1'b1, 21, 1'b0, 1'b0);
        q_id.push_back(21);
        q_last.push_back(0);
        step();
        drive(1'b0, 0, 1'b0, 1'b0);
        en = 1'b0;
        step();
        chk("t5_rdy", 32'(bus.id_in_ready), 32'd0);
        chk("t5_vld", 32'(bus.id_out_valid), 32'd0);
        drive(1'b1, 22, 1'b0, 1'b1);
        step();
        step();
        chk("t5_cnt", 32'(bus.count), 32'd2);
        drive(1'b0, 0, 1'b0, 1'b0);
        en = 1'b1;
        step();
        chk("t5_rdy_back", 32'(bus.id_in_ready), 32'd1);
        drain("t5");

        // Localised reset mid-handshake discards queued entries.
        fill(30, 3);
        chk("t6_cnt3", 32'(bus.count), 32'd3);
        drive(1'b1, 33, 1'b0, 1'b1);
        sync_rst = 1'b1;
        step();
        chk("t6_cnt", 32'(bus.count), 32'd0);
        chk("t6_vld", 32'(bus.id_out_valid), 32'd0);
        chk("t6_rdy", 32'(bus.id_in_ready), 32'd0);
        sync_rst = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b1);
        step();
        chk("t6_rdy_back", 32'(bus.id_in_ready), 32'd1);
        chk("t6_vld_idle", 32'(bus.id_out_valid), 32'd0);
        q_id.delete();
        q_last.delete();
        drive(1'b1, 40, 1'b1, 1'b0);
        q_id.push_back(40);
        q_last.push_back(1);
        step();
        chk("t6_cnt1", 32'(bus.count), 32'd1);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/sha256_id_buf.md
Name: sha256_id_buf

Overview:
- Small synchronous first-word-fall-through FIFO placed directly downstream of the packet-ID issuer.
- Decouples the always-valid ID stream from the hash engine's message-packet consumption rate.
- Absorbs back-pressure so IDs are consumed strictly in issue order, one per hashed message.
- Carries ID plus last flag; the count output is exposed for debug and flow monitoring.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, at least 2.
- ID_W, 6, width of packet ID.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- nrst  in  1  reset; synchronous, active-low.
- en  in  1  block enable.
- sync_rst  in  1  synchronous localised reset, active-high; same effect as nrst.
- id_in  in  ID_W  ID from issuer.
- id_in_last  in  1  last flag accompanying id_in.
- id_in_valid  in  1  upstream valid.
- id_in_ready  out  1  FIFO can accept.
- id_out  out  ID_W  head-of-FIFO ID.
- id_out_last  out  1  head-of-FIFO last flag.
- id_out_valid  out  1  head entry present.
- id_out_ready  in  1  downstream accepts.
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

Behaviour:
- Reset: on a clk edge with nrst==0 or sync_rst==1:
  - write and read pointers are cleared to 0; count=0.
  - id_in_ready=0, id_out_valid=0, id_out=0, id_out_last=0.
  - Storage contents need no clearing.
  - Reset wins over every other event, including mid-transfer; in-flight entries are discarded.
- Pointers: ($clog2(DEPTH)+1) bits each.
  - The MSB is the wrap bit; the low bits index storage.
  - Empty when wr_ptr==rd_ptr.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2*DEPTH naturally.
- Push when id_in_valid && id_in_ready.
  - {id_in_last,id_in} is written to mem[wr_ptr] and wr_ptr increments.
- Pop when id_out_valid && id_out_ready.
  - rd_ptr increments.
- Ready and valid:
  - id_in_ready = en && !full, registered.
  - id_out_valid = en && !empty, registered.
  - id_out/id_out_last are driven from mem[rd_ptr] as a registered head, or as a combinational read of registered storage; both are acceptable provided the cycle timing below holds.
- Latency: a push in cycle N gives id_out_valid=1 with that data in cycle N+1 (FIFO previously empty). No same-cycle bypass.
- Simultaneous push and pop in one cycle:
  - Both occur; count unchanged.
  - Legal at any occupancy where both handshakes are true.
- Full: id_in_ready is low. A pop in cycle N raises id_in_ready in cycle N+1.
- Empty: id_out_valid is low. id_out holds its last value and is not meaningful.
- count = wr_ptr - rd_ptr, unsigned, in ($clog2(DEPTH)+1) bits; updated the cycle after each push or pop.
- en==0:
  - Pointers and storage are held.
  - id_in_ready=0 and id_out_valid=0 from the next cycle; no push or pop can occur.
  - On en returning to 1, contents resume unchanged, in order.
- Data is never modified; the last flag travels with its ID.
- No overflow or underflow is possible by construction.

Decomposition:
- Shared package sha256_pkg holds:
  - localparam ID_W=6.
  - typedef logic [ID_W-1:0] id_t.
  - typedef struct packed {logic last; id_t id;} id_entry_t.
- Issuer, buffer and downstream consumers all use these.
- One sub-module is natural: sha256_fifo.
  - Generic width/depth storage plus pointer logic.
  - sha256_id_buf instantiates it with width ID_W+1 and adds en gating.
  - The same FIFO is reused later for hash-output buffering.

Test Plan:
1. Reset then idle with no stimulus -> id_in_ready=1 from the first cycle after reset; id_out_valid=0; count=0.
2. Push IDs 5,6,7,8 with id_out_ready=0 -> count=4 and id_in_ready=0; a fifth valid ID (9) is not accepted. Assert ready -> outputs 5,6,7,8 in order, then id_out_valid=0.
3. Continuous push and pop, 20 IDs 0..19 -> one ID per cycle sustained; count stays at 1; output order equals input order; pointer wrap exercised.
4. Full FIFO with a push attempt and a pop in the same cycle -> pop completes; push is accepted the following cycle; count 4->3->4.
5. en=0 with 2 entries -> id_in_ready=0 and id_out_valid=0 next cycle. en=1 -> the same 2 entries emerge with last flags intact.
6. sync_rst=1 pulse with 3 entries while a handshake is active -> count=0, id_out_valid=0 the next cycle; entries issued before the reset never appear.
